// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-add slice iterated LSB first over a WIDTH-bit
// operand pair, with start/ready request handshake and valid/ready result handshake.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             ready_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             valid_o,
  input  logic             out_ready_in
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  logic ha1_s, ha1_c, ha2_c, bit_s, bit_c, last_bit;

  // One full-add slice on the current LSBs: two half adders plus OR.
  always_comb begin
    ha1_s    = a_q[0] ^ b_q[0];
    ha1_c    = a_q[0] & b_q[0];
    bit_s    = ha1_s ^ carry_q;
    ha2_c    = ha1_s & carry_q;
    bit_c    = ha1_c | ha2_c;
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 has reached position 0.
  if (WIDTH == 1) begin : g_res_w1
    assign res_d = bit_s;
  end else begin : g_res_wn
    assign res_d = {bit_s, res_q[WIDTH-1:1]};
  end

  // Control FSM with all handshake and result outputs registered.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      ready_o <= 1'b1;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      sum_o   <= '0;
      carry_o <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_in) begin
            a_q     <= a_in;
            b_q     <= b_in;
            carry_q <= c_in;
            cnt_q   <= '0;
            state_q <= StRun;
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
          end
        end
        StRun: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= bit_c;
          res_q   <= res_d;
          if (last_bit) begin
            sum_o   <= res_d;
            carry_o <= bit_c;
            cnt_q   <= '0;
            state_q <= StDone;
            busy_o  <= 1'b0;
            valid_o <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StDone: begin
          // Result held under back-pressure; start_in is not looked at here.
          if (out_ready_in) begin
            state_q <= StIdle;
            valid_o <= 1'b0;
            ready_o <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a_in, b_in;
  logic             c_in;
  logic             ready, busy, valid, carry;
  logic [WIDTH-1:0] sum;
  logic             out_ready;

  logic [WIDTH:0] sb_q[$];
  int tests_run = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .start_in     (start),
    .a_in         (a_in),
    .b_in         (b_in),
    .c_in         (c_in),
    .ready_o      (ready),
    .busy_o       (busy),
    .sum_o        (sum),
    .carry_o      (carry),
    .valid_o      (valid),
    .out_ready_in (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, follow it to DONE, compare against the scoreboard, then drain.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                        input int bp, input bit toggle);
    int guard;
    int cycles;
    int busy_cnt;
    logic [WIDTH:0] exp;
    guard = 0;
    while (!ready && guard < 50) begin
      tick();
      guard++;
    end
    check("ready_before_op", ready, 1);
    a_in  = a;
    b_in  = b;
    c_in  = c;
    start = 1'b1;
    sb_q.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c});
    tick();
    start    = 1'b0;
    busy_cnt = busy ? 1 : 0;
    cycles   = 0;
    while (!valid && cycles < 50) begin
      if (toggle) begin
        a_in = WIDTH'($urandom);
        b_in = WIDTH'($urandom);
        c_in = 1'($urandom);
      end
      tick();
      cycles++;
      if (busy) busy_cnt++;
    end
    check("latency", cycles, WIDTH);
    check("busy_cycles", busy_cnt, WIDTH);
    check("sb_depth", sb_q.size(), 1);
    if (sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      check("sum", sum, exp[WIDTH-1:0]);
      check("carry", carry, exp[WIDTH]);
      for (int i = 0; i < bp; i++) begin
        start = 1'b1;
        a_in  = ~a;
        b_in  = WIDTH'($urandom);
        tick();
        check("bp_valid", valid, 1);
        check("bp_sum", sum, exp[WIDTH-1:0]);
        check("bp_carry", carry, exp[WIDTH]);
        check("bp_ready", ready, 0);
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("drain_valid", valid, 0);
    check("drain_ready", ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    c_in      = 1'b0;
    repeat (2) tick();
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_sum", sum, 0);
    check("rst_carry", carry, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_ready", ready, 1);
    check("idle_busy", busy, 0);
    check("idle_valid", valid, 0);

    run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    run_op(8'hA5, 8'h5A, 1'b1, 0, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    run_op(8'h3C, 8'hC3, 1'b1, 5, 1'b0);
    run_op(8'h12, 8'h34, 1'b0, 0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
             1'($urandom));
    end

    // Abort an op part-way through RUN with the asynchronous reset.
    a_in  = 8'h55;
    b_in  = 8'h33;
    c_in  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("abort_ready", ready, 1);
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    check("abort_sum", sum, 0);
    check("abort_carry", carry, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_abort_ready", ready, 1);
    check("post_abort_valid", valid, 0);
    run_op(8'h01, 8'h01, 1'b0, 0, 1'b0);

    check("sb_final_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, n_fail);
    $finish;
  end

endmodule
